// File: rtl/tlk2711_rx_cmd.sv
// TLK2711 receive command block: turns RX frame descriptors into DataMover S2MM write
// commands against a software-programmed ring of DDR slots, with counters, status and irq.
module tlk2711_rx_cmd #(
  parameter logic [11:0] ADDR_BASE = 12'h100,
  parameter int          MAX_SLOTS = 256
) (
  input  logic        i_clk,
  input  logic        i_soft_rst,
  input  logic [31:0] i_reg_wdata,
  input  logic [11:0] i_reg_waddr,
  input  logic        i_reg_wen,
  input  logic        i_reg_ren,
  input  logic [11:0] i_reg_raddr,
  output logic [31:0] o_reg_rdata,
  output logic        o_reg_valid,
  input  logic        i_rx_frame_valid,
  input  logic [15:0] i_rx_frame_len,
  output logic        o_rx_frame_ready,
  input  logic        i_dma_wrcmd_ready,
  output logic [71:0] o_dma_wrcmd_data,
  output logic        o_dma_wrcmd_valid,
  input  logic        i_dma_wr_done,
  output logic        o_rx_irq,
  output logic        o_rx_busy
);

  localparam int SLOT_W = $clog2(MAX_SLOTS);

  localparam logic [11:0] A_BASE = ADDR_BASE + 12'h00;
  localparam logic [11:0] A_SLOT = ADDR_BASE + 12'h04;
  localparam logic [11:0] A_CTRL = ADDR_BASE + 12'h08;
  localparam logic [11:0] A_STAT = ADDR_BASE + 12'h0C;
  localparam logic [11:0] A_FCNT = ADDR_BASE + 12'h10;
  localparam logic [11:0] A_LAST = ADDR_BASE + 12'h14;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_CMD        = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]       r_base_addr;
  logic [22:0]       r_slot_size;
  logic              r_enable;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [SLOT_W-1:0] r_slot_idx;
  logic [31:0]       r_frame_cnt;
  logic [22:0]       r_last_len;
  logic [22:0]       r_btt;
  logic              r_trunc;
  logic [71:0]       r_cmd_dat;
  logic              r_irq;
  logic [31:0]       r_rdata;
  logic              r_rvld;

  logic              w_frame_rdy;
  logic              w_cmd_vld;
  logic              w_wr_base;
  logic              w_wr_slot;
  logic              w_wr_ctrl;
  logic              w_clear;
  logic              w_take;
  logic              w_done;
  logic [22:0]       w_len;
  logic              w_trunc;
  logic [22:0]       w_btt;
  logic [31:0]       w_prod;
  logic [31:0]       w_addr;
  logic [SLOT_W:0]   w_idx_inc;
  logic [SLOT_W:0]   w_slot_lim;
  logic [SLOT_W-1:0] w_idx_nxt;
  logic              w_busy;
  logic [31:0]       w_rd_mux;

  always_ff @(posedge i_clk) begin
    if (i_soft_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Descriptors are only accepted while enabled, so none is swallowed on the
  // cycle the FSM falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_rdy = 1'b0;
    w_cmd_vld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_enable) w_state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        w_frame_rdy = r_enable;
        if (!r_enable) begin
          w_state_nxt = S_IDLE;
        end else if (i_rx_frame_valid && (i_rx_frame_len != 16'd0)) begin
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        w_cmd_vld = 1'b1;
        if (i_dma_wrcmd_ready) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_dma_wr_done) w_state_nxt = r_enable ? S_WAIT_FRAME : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_base = i_reg_wen && (i_reg_waddr == A_BASE);
  assign w_wr_slot = i_reg_wen && (i_reg_waddr == A_SLOT);
  assign w_wr_ctrl = i_reg_wen && (i_reg_waddr == A_CTRL);
  assign w_clear   = w_wr_ctrl && i_reg_wdata[1];

  assign w_take  = w_frame_rdy && i_rx_frame_valid && (i_rx_frame_len != 16'd0);
  assign w_done  = (r_state == S_WAIT_DONE) && i_dma_wr_done;
  assign w_busy  = (r_state != S_IDLE);

  assign w_len   = {7'd0, i_rx_frame_len};
  assign w_trunc = (w_len > r_slot_size);
  assign w_btt   = w_trunc ? r_slot_size : w_len;

  // Slot address wraps modulo 2^32 by construction of the 32-bit product and sum.
  assign w_prod  = {{(32-SLOT_W){1'b0}}, r_slot_idx} * {9'd0, r_slot_size};
  assign w_addr  = r_base_addr + w_prod;

  assign w_idx_inc  = {1'b0, r_slot_idx} + (SLOT_W+1)'(1);
  assign w_slot_lim = (r_slot_cnt == '0) ? (SLOT_W+1)'(1) : {1'b0, r_slot_cnt};
  assign w_idx_nxt  = (w_idx_inc >= w_slot_lim) ? '0 : w_idx_inc[SLOT_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_soft_rst) begin
      r_base_addr <= '0;
      r_slot_size <= '0;
      r_enable    <= 1'b0;
      r_slot_cnt  <= '0;
      r_slot_idx  <= '0;
      r_frame_cnt <= '0;
      r_last_len  <= '0;
      r_btt       <= '0;
      r_trunc     <= 1'b0;
      r_cmd_dat   <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_base) r_base_addr <= i_reg_wdata;
      if (w_wr_slot) r_slot_size <= i_reg_wdata[22:0];
      if (w_wr_ctrl) begin
        r_enable   <= i_reg_wdata[0];
        r_slot_cnt <= i_reg_wdata[8 +: SLOT_W];
      end

      // Command word is frozen here so a later clear cannot disturb it.
      if (w_take) begin
        r_cmd_dat <= {4'h0, r_frame_cnt[3:0], w_addr, 9'b0_1_000000_1, w_btt};
        r_btt     <= w_btt;
      end

      r_irq <= w_done;
      if (w_done) r_last_len <= r_btt;

      if (w_clear) begin
        r_frame_cnt <= '0;
        r_slot_idx  <= '0;
        r_trunc     <= 1'b0;
      end else begin
        if (w_take && w_trunc) r_trunc <= 1'b1;
        if (w_done) begin
          r_frame_cnt <= r_frame_cnt + 32'd1;
          r_slot_idx  <= w_idx_nxt;
        end
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_reg_raddr)
      A_BASE:  w_rd_mux = r_base_addr;
      A_SLOT:  w_rd_mux = {9'd0, r_slot_size};
      A_CTRL:  w_rd_mux = {16'd0, 8'(r_slot_cnt), 7'd0, r_enable};
      A_STAT:  w_rd_mux = {r_frame_cnt[15:0], 8'(r_slot_idx), 6'd0, r_trunc, w_busy};
      A_FCNT:  w_rd_mux = r_frame_cnt;
      A_LAST:  w_rd_mux = {9'd0, r_last_len};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_soft_rst) begin
      r_rdata <= '0;
      r_rvld  <= 1'b0;
    end else begin
      r_rvld <= i_reg_ren;
      if (i_reg_ren) r_rdata <= w_rd_mux;
    end
  end

  assign o_reg_rdata       = r_rdata;
  assign o_reg_valid       = r_rvld;
  assign o_rx_frame_ready  = w_frame_rdy;
  assign o_dma_wrcmd_data  = r_cmd_dat;
  assign o_dma_wrcmd_valid = w_cmd_vld;
  assign o_rx_irq          = r_irq;
  assign o_rx_busy         = w_busy;

endmodule

// File: tb/tb_tlk2711_rx_cmd.sv
// Bench for tlk2711_rx_cmd: directed scenarios plus randomized frames, checked against
// a ring-buffer model that works from slot arithmetic rather than the FSM.
module tb_tlk2711_rx_cmd;

  localparam logic [11:0] AB     = 12'h100;
  localparam logic [11:0] R_BASE = AB + 12'h00;
  localparam logic [11:0] R_SLOT = AB + 12'h04;
  localparam logic [11:0] R_CTRL = AB + 12'h08;
  localparam logic [11:0] R_STAT = AB + 12'h0C;
  localparam logic [11:0] R_FCNT = AB + 12'h10;
  localparam logic [11:0] R_LAST = AB + 12'h14;

  logic        i_clk = 1'b0;
  logic        i_soft_rst = 1'b1;
  logic [31:0] i_reg_wdata = '0;
  logic [11:0] i_reg_waddr = '0;
  logic        i_reg_wen = 1'b0;
  logic        i_reg_ren = 1'b0;
  logic [11:0] i_reg_raddr = '0;
  logic [31:0] o_reg_rdata;
  logic        o_reg_valid;
  logic        i_rx_frame_valid = 1'b0;
  logic [15:0] i_rx_frame_len = '0;
  logic        o_rx_frame_ready;
  logic        i_dma_wrcmd_ready = 1'b0;
  logic [71:0] o_dma_wrcmd_data;
  logic        o_dma_wrcmd_valid;
  logic        i_dma_wr_done = 1'b0;
  logic        o_rx_irq;
  logic        o_rx_busy;

  always #5 i_clk = ~i_clk;

  tlk2711_rx_cmd #(.ADDR_BASE(AB), .MAX_SLOTS(256)) dut (
    .i_clk(i_clk), .i_soft_rst(i_soft_rst),
    .i_reg_wdata(i_reg_wdata), .i_reg_waddr(i_reg_waddr), .i_reg_wen(i_reg_wen),
    .i_reg_ren(i_reg_ren), .i_reg_raddr(i_reg_raddr),
    .o_reg_rdata(o_reg_rdata), .o_reg_valid(o_reg_valid),
    .i_rx_frame_valid(i_rx_frame_valid), .i_rx_frame_len(i_rx_frame_len),
    .o_rx_frame_ready(o_rx_frame_ready),
    .i_dma_wrcmd_ready(i_dma_wrcmd_ready), .o_dma_wrcmd_data(o_dma_wrcmd_data),
    .o_dma_wrcmd_valid(o_dma_wrcmd_valid), .i_dma_wr_done(i_dma_wr_done),
    .o_rx_irq(o_rx_irq), .o_rx_busy(o_rx_busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int irq_total = 0;

  always @(negedge i_clk) if (o_rx_irq) irq_total++;

  // Reference model of the ring
  logic [31:0] m_base, m_cnt;
  logic [22:0] m_slot, m_last;
  logic [7:0]  m_slots, m_idx;
  bit          m_trunc, m_en;

  task automatic m_reset();
    m_base = '0; m_cnt = '0; m_slot = '0; m_last = '0;
    m_slots = '0; m_idx = '0; m_trunc = 0; m_en = 0;
  endtask

  function automatic logic [22:0] m_btt(input logic [15:0] len);
    return ({7'd0, len} > m_slot) ? m_slot : {7'd0, len};
  endfunction

  function automatic logic [71:0] m_cmd(input logic [15:0] len);
    logic [31:0] addr;
    addr = m_base + 32'(m_idx) * 32'(m_slot);
    return {4'h0, m_cnt[3:0], addr, 1'b0, 1'b1, 6'd0, 1'b1, m_btt(len)};
  endfunction

  function automatic logic [31:0] m_status(input bit busy);
    return {m_cnt[15:0], m_idx, 6'd0, m_trunc, busy};
  endfunction

  function automatic logic [31:0] ctrl_word(input bit en, input bit clr);
    return {16'd0, m_slots, 6'd0, clr, en};
  endfunction

  task automatic m_complete(input logic [15:0] len, input bit clr);
    int n;
    n = (m_slots == 0) ? 1 : int'(m_slots);
    m_last = m_btt(len);
    m_cnt  = m_cnt + 1;
    m_idx  = (int'(m_idx) + 1 >= n) ? 8'd0 : m_idx + 8'd1;
    if (clr) begin m_cnt = '0; m_idx = '0; m_trunc = 0; end
  endtask

  task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
    i_reg_wen = 1; i_reg_waddr = a; i_reg_wdata = d;
    @(posedge i_clk); #1;
    i_reg_wen = 0;
  endtask

  task automatic reg_read(input logic [11:0] a, output logic [31:0] d,
                          output logic v1, output logic v2);
    i_reg_ren = 1; i_reg_raddr = a;
    @(posedge i_clk); #1;
    i_reg_ren = 0;
    v1 = o_reg_valid; d = o_reg_rdata;
    @(posedge i_clk); #1;
    v2 = o_reg_valid;
  endtask

  task automatic configure(input logic [31:0] b, input logic [22:0] s, input logic [7:0] n);
    m_base = b; m_slot = s; m_slots = n;
    reg_write(R_BASE, b);
    reg_write(R_SLOT, {9'd0, s});
    reg_write(R_CTRL, ctrl_word(1, 1));
    m_cnt = '0; m_idx = '0; m_trunc = 0; m_en = 1;
  endtask

  // Drives one descriptor through the whole handshake and keeps the model in step.
  task automatic run_frame(input logic [15:0] len, input int bp, input int dly,
                           input bit dis, input bit clr,
                           output logic [71:0] cmd, output bit seen, output bit bp_ok);
    bit acc;
    acc = 0; seen = 0; bp_ok = 1; cmd = '0;
    i_rx_frame_valid = 1; i_rx_frame_len = len;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (o_rx_frame_ready) acc = 1;
      @(posedge i_clk); #1;
    end
    i_rx_frame_valid = 0;
    if (!acc || len == 16'd0) return;
    if ({7'd0, len} > m_slot) m_trunc = 1;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (o_dma_wrcmd_valid) seen = 1;
      else begin @(posedge i_clk); #1; end
    end
    if (!seen) return;
    cmd = o_dma_wrcmd_data;
    for (int i = 0; i < bp; i++) begin
      @(posedge i_clk); #1;
      if (!o_dma_wrcmd_valid || o_dma_wrcmd_data !== cmd || o_rx_frame_ready) bp_ok = 0;
    end
    i_dma_wrcmd_ready = 1;
    @(posedge i_clk); #1;
    i_dma_wrcmd_ready = 0;
    if (dis) begin reg_write(R_CTRL, ctrl_word(0, 0)); m_en = 0; end
    for (int i = 0; i < dly; i++) begin @(posedge i_clk); #1; end
    i_dma_wr_done = 1;
    if (clr) begin i_reg_wen = 1; i_reg_waddr = R_CTRL; i_reg_wdata = ctrl_word(m_en, 1); end
    @(posedge i_clk); #1;
    i_dma_wr_done = 0; i_reg_wen = 0;
    m_complete(len, clr);
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v1, v2;
    repeat (3) @(posedge i_clk); #1;
    i_soft_rst = 0; m_reset();
    n_total++;
    if ({o_reg_valid, o_rx_frame_ready, o_dma_wrcmd_valid, o_rx_irq, o_rx_busy} !== 5'b0 ||
        o_dma_wrcmd_data !== 72'd0 || o_reg_rdata !== 32'd0) begin
      $display("FAIL reset_outputs: got busy=%b cmd_vld=%b cmd=%h, want all zero",
               o_rx_busy, o_dma_wrcmd_valid, o_dma_wrcmd_data);
    end else n_pass++;
    foreach (R_BASE[i]) begin end
    reg_read(R_CTRL, d, v1, v2);
    n_total++;
    if (d !== 32'd0 || v1 !== 1'b1) $display("FAIL reset_ctrl: got %h v=%b, want 0 v=1", d, v1);
    else n_pass++;
    reg_read(R_STAT, d, v1, v2);
    n_total++;
    if (d !== 32'd0) $display("FAIL reset_status: got %h, want 0", d);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [71:0] cmd, exp; bit seen, ok; int i0; logic [31:0] d; logic v1, v2;
    configure(32'h1000_0000, 23'h1000, 8'd4);
    exp = m_cmd(16'h200); i0 = irq_total;
    run_frame(16'h200, 0, 3, 0, 0, cmd, seen, ok);
    n_total++;
    if (!seen || cmd !== exp) $display("FAIL basic_cmd: got %h seen=%b, want %h", cmd, seen, exp);
    else n_pass++;
    n_total++;
    if (cmd[22:0] !== 23'h200 || cmd[63:32] !== 32'h1000_0000 || cmd[67:64] !== 4'd0)
      $display("FAIL basic_fields: got btt=%h addr=%h tag=%h, want 200 10000000 0",
               cmd[22:0], cmd[63:32], cmd[67:64]);
    else n_pass++;
    n_total++;
    if (irq_total - i0 !== 1) $display("FAIL basic_irq: got %0d pulses, want 1", irq_total - i0);
    else n_pass++;
    reg_read(R_FCNT, d, v1, v2);
    n_total++;
    if (d !== 32'd1) $display("FAIL basic_frame_cnt: got %0d, want 1", d);
    else n_pass++;
    reg_read(R_LAST, d, v1, v2);
    n_total++;
    if (d !== 32'h200) $display("FAIL basic_last_len: got %h, want 200", d);
    else n_pass++;
  endtask

  task automatic test_ring_wrap();
    logic [71:0] cmd, exp; bit seen, ok; logic [15:0] len; logic [31:0] d, ea; logic v1, v2;
    configure(32'h1000_0000, 23'h1000, 8'd4);
    for (int i = 0; i < 5; i++) begin
      len = 16'($urandom_range(1, 'h1000));
      exp = m_cmd(len);
      ea  = 32'h1000_0000 + 32'(i % 4) * 32'h1000;
      run_frame(len, 0, $urandom_range(0, 4), 0, 0, cmd, seen, ok);
      n_total++;
      if (!seen || cmd !== exp || cmd[63:32] !== ea)
        $display("FAIL wrap_cmd%0d: got %h, want %h addr %h", i, cmd, exp, ea);
      else n_pass++;
    end
    reg_read(R_STAT, d, v1, v2);
    n_total++;
    if (d[15:8] !== 8'd1 || d !== m_status(1)) $display("FAIL wrap_status: got %h, want %h", d, m_status(1));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [71:0] cmd, exp; bit seen, ok;
    exp = m_cmd(16'h345);
    run_frame(16'h345, 10, 1, 0, 0, cmd, seen, ok);
    n_total++;
    if (!ok || !seen || cmd !== exp)
      $display("FAIL backpressure: got stable=%b cmd=%h, want stable=1 cmd=%h", ok, cmd, exp);
    else n_pass++;
  endtask

  task automatic test_trunc_zero();
    logic [71:0] cmd, exp; bit seen, ok, stray; int i0; logic [31:0] d, c0; logic v1, v2;
    exp = m_cmd(16'h2000);
    run_frame(16'h2000, 0, 2, 0, 0, cmd, seen, ok);
    n_total++;
    if (!seen || cmd !== exp || cmd[22:0] !== 23'h1000)
      $display("FAIL trunc_cmd: got %h, want %h", cmd, exp);
    else n_pass++;
    reg_read(R_STAT, d, v1, v2);
    n_total++;
    if (d[1] !== 1'b1 || d !== m_status(1)) $display("FAIL trunc_sticky: got %h, want %h", d, m_status(1));
    else n_pass++;
    c0 = m_cnt; i0 = irq_total; stray = 0;
    run_frame(16'h0, 0, 0, 0, 0, cmd, seen, ok);
    for (int i = 0; i < 6; i++) begin
      if (o_dma_wrcmd_valid) stray = 1;
      @(posedge i_clk); #1;
    end
    n_total++;
    if (seen || stray || irq_total != i0)
      $display("FAIL zero_len: got cmd=%b irq=%0d, want no cmd and no irq", seen | stray, irq_total - i0);
    else n_pass++;
    reg_read(R_FCNT, d, v1, v2);
    n_total++;
    if (d !== c0) $display("FAIL zero_len_cnt: got %0d, want %0d", d, c0);
    else n_pass++;
  endtask

  task automatic test_disable_mid();
    logic [71:0] cmd, exp; bit seen, ok; int i0;
    exp = m_cmd(16'h80); i0 = irq_total;
    run_frame(16'h80, 0, 3, 1, 0, cmd, seen, ok);
    @(posedge i_clk); #1;
    n_total++;
    if (!seen || cmd !== exp || irq_total - i0 !== 1 || o_rx_busy !== 1'b0)
      $display("FAIL disable_mid: got busy=%b irq=%0d cmd=%h, want busy=0 irq=1 cmd=%h",
               o_rx_busy, irq_total - i0, cmd, exp);
    else n_pass++;
    reg_write(R_CTRL, ctrl_word(1, 0)); m_en = 1;
  endtask

  task automatic test_clear_done();
    logic [71:0] cmd; bit seen, ok; logic [31:0] d; logic v1, v2;
    run_frame(16'h44, 0, 2, 0, 1, cmd, seen, ok);
    reg_read(R_FCNT, d, v1, v2);
    n_total++;
    if (d !== 32'd0 || m_cnt !== 32'd0) $display("FAIL clear_with_done: got cnt %0d, want 0", d);
    else n_pass++;
    reg_read(R_STAT, d, v1, v2);
    n_total++;
    if (d !== m_status(1)) $display("FAIL clear_status: got %h, want %h", d, m_status(1));
    else n_pass++;
  endtask

  task automatic test_rst_in_cmd();
    bit acc, seen; logic [31:0] d; logic v1, v2;
    acc = 0; seen = 0;
    i_rx_frame_valid = 1; i_rx_frame_len = 16'h100;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (o_rx_frame_ready) acc = 1;
      @(posedge i_clk); #1;
    end
    i_rx_frame_valid = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (o_dma_wrcmd_valid) seen = 1;
      else begin @(posedge i_clk); #1; end
    end
    i_soft_rst = 1;
    @(posedge i_clk); #1;
    n_total++;
    if (!seen || {o_reg_valid, o_rx_frame_ready, o_dma_wrcmd_valid, o_rx_irq, o_rx_busy} !== 5'b0 ||
        o_dma_wrcmd_data !== 72'd0)
      $display("FAIL rst_in_cmd: got reached_cmd=%b busy=%b cmd_vld=%b cmd=%h, want 1 and zeros",
               seen, o_rx_busy, o_dma_wrcmd_valid, o_dma_wrcmd_data);
    else n_pass++;
    i_soft_rst = 0; m_reset();
    reg_read(R_BASE, d, v1, v2);
    n_total++;
    if (d !== 32'd0) $display("FAIL rst_base: got %h, want 0", d);
    else n_pass++;
  endtask

  task automatic test_reg_reads();
    logic [31:0] d; logic v1, v2;
    configure(32'hA5A5_0000, 23'h40, 8'd3);
    @(posedge i_clk); #1;
    n_total++;
    if (o_reg_valid !== 1'b0) $display("FAIL rd_idle_valid: got %b, want 0", o_reg_valid);
    else n_pass++;
    reg_read(R_STAT, d, v1, v2);
    n_total++;
    if (v1 !== 1'b1 || v2 !== 1'b0 || d !== m_status(1))
      $display("FAIL rd_status: got %h v=%b%b, want %h v=10", d, v1, v2, m_status(1));
    else n_pass++;
    reg_write(R_STAT, 32'hFFFF_FFFF);
    reg_read(12'h1FC, d, v1, v2);
    n_total++;
    if (v1 !== 1'b1 || v2 !== 1'b0 || d !== 32'd0)
      $display("FAIL rd_unmapped: got %h v=%b%b, want 0 v=10", d, v1, v2);
    else n_pass++;
    reg_read(R_SLOT, d, v1, v2);
    n_total++;
    if (d !== 32'h40) $display("FAIL rd_slot: got %h, want 40", d);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [71:0] cmd, exp; bit seen, ok; logic [15:0] len; int i0, nfr; logic [31:0] d; logic v1, v2;
    configure($urandom, 23'($urandom_range(1, 'h8000)), 8'($urandom_range(0, 7)));
    i0 = irq_total; nfr = 0;
    for (int i = 0; i < 20; i++) begin
      len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 'hFFFF));
      exp = m_cmd(len);
      run_frame(len, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, cmd, seen, ok);
      if (len != 0) nfr++;
      n_total++;
      if (seen !== (len != 0) || (len != 0 && cmd !== exp))
        $display("FAIL rand_cmd%0d: got %h seen=%b, want %h len=%h", i, cmd, seen, exp, len);
      else n_pass++;
    end
    n_total++;
    if (irq_total - i0 !== nfr) $display("FAIL rand_irq: got %0d, want %0d", irq_total - i0, nfr);
    else n_pass++;
    reg_read(R_STAT, d, v1, v2);
    n_total++;
    if (d !== m_status(1)) $display("FAIL rand_status: got %h, want %h", d, m_status(1));
    else n_pass++;
    reg_read(R_LAST, d, v1, v2);
    n_total++;
    if (d !== {9'd0, m_last}) $display("FAIL rand_last_len: got %h, want %h", d, m_last);
    else n_pass++;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_ring_wrap();
    test_backpressure();
    test_trunc_zero();
    test_disable_mid();
    test_clear_done();
    test_rst_in_cmd();
    test_reg_reads();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tlk2711_rx_cmd.md
Name: tlk2711_rx_cmd

Overview:
Receive-side command block for the TLK2711 link. It mirrors the transmit command path. Software programs a ring of receive buffer slots in DDR through the register interface. The block accepts frame descriptors from the RX link framer and issues 72-bit DataMover S2MM write commands, one per frame. It waits for write completion, advances the ring, and exposes counters, status and a per-frame interrupt pulse.

Parameters:
ADDR_BASE, 12'h100, base register address of this block's register window
MAX_SLOTS, 256, maximum ring slot count (slot-count field is 8 bits)

Ports:
i_clk  input  1  block clock
i_soft_rst  input  1  synchronous active-high reset
i_reg_wdata  input  32  register write data
i_reg_waddr  input  12  register write address
i_reg_wen  input  1  register write strobe, single cycle
i_reg_ren  input  1  register read strobe, single cycle
i_reg_raddr  input  12  register read address
o_reg_rdata  output  32  read data
o_reg_valid  output  1  read data valid, one-cycle pulse
i_rx_frame_valid  input  1  frame descriptor valid from RX framer
i_rx_frame_len  input  16  frame payload length in bytes
o_rx_frame_ready  output  1  descriptor accepted when valid&ready
i_dma_wrcmd_ready  input  1  DataMover S2MM command ready
o_dma_wrcmd_data  output  72  S2MM command word
o_dma_wrcmd_valid  output  1  command valid
i_dma_wr_done  input  1  one-cycle pulse: S2MM status OK for the last command
o_rx_irq  output  1  one-cycle pulse per completed frame
o_rx_busy  output  1  high in any state except IDLE

Behaviour:
- Reset and clock: one clock, i_clk. i_soft_rst is synchronous and active-high. It has priority over all other inputs, returns the FSM to IDLE, and zeroes every register, counter and output.
- Registers, at offsets from ADDR_BASE:
  - 0x00 BASE_ADDR, RW, 32 bits.
  - 0x04 SLOT_SIZE, RW, bits [22:0]; it is both the byte stride and the maximum BTT.
  - 0x08 CTRL: bit0 enable (RW); bit1 clear (write-1, self-clearing); bits [15:8] slot count (RW, 0 treated as 1).
  - 0x0C STATUS, RO: bit0 busy; bit1 truncation sticky; [15:8] current slot index; [31:16] frame count [15:0].
  - 0x10 FRAME_CNT, RO, 32 bits.
  - 0x14 LAST_LEN, RO: BTT of the last completed frame.
- Register reads: rdata is registered; o_reg_valid pulses exactly 1 cycle after i_reg_ren. Unmapped read addresses return 0 with valid asserted. Writes to RO or unmapped addresses are ignored.
- FSM states:
  - IDLE: leave when enable=1 -> WAIT_FRAME.
  - WAIT_FRAME: o_rx_frame_ready=1.
    - enable=0 -> IDLE.
    - valid&ready with len==0 -> descriptor consumed, no command issued, stay in WAIT_FRAME.
    - valid&ready with len!=0 -> latch length, go to CMD.
  - CMD: o_dma_wrcmd_valid=1, data held stable until i_dma_wrcmd_ready, then go to WAIT_DONE.
  - WAIT_DONE: on i_dma_wr_done:
    - pulse o_rx_irq next cycle, FRAME_CNT+1, LAST_LEN=BTT;
    - slot index +1, wrapping to 0 at slot count;
    - then WAIT_FRAME if enable=1, otherwise IDLE.
- Disable mid-frame: clearing enable in CMD or WAIT_DONE does not abort; the current frame completes, then the FSM goes to IDLE.
- Command word: [22:0] BTT; [23]=1 (INCR); [29:24]=0; [30]=1 (EOF); [31]=0; [63:32] address; [67:64] FRAME_CNT[3:0]; [71:68]=0.
- Address: BASE_ADDR + slot_index*SLOT_SIZE, computed as a 32-bit product that wraps modulo 2^32. It is registered on entry to CMD.
- Truncation: if len > SLOT_SIZE, BTT = SLOT_SIZE and the truncation sticky bit sets; it stays set until a clear.
- Clear: zeroes FRAME_CNT, slot index and the sticky bit. It does not change the FSM state.
- Simultaneous clear and completion in the same cycle: clear wins and the counters read 0.
- Clear while a frame is in flight: the current command is unaffected.
- i_dma_wr_done outside WAIT_DONE is ignored.

Test Plan:
- Basic frame: BASE=0x1000_0000, SLOT=0x1000, slots=4, enable, one frame len=0x200 -> cmd data has BTT=0x200, addr=0x1000_0000, tag=0; after done, one irq pulse and FRAME_CNT=1.
- Ring wrap: with the setup above, send 5 frames -> addresses 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000, then 0x1000_0000; STATUS[15:8]=1 at the end.
- Backpressure: hold i_dma_wrcmd_ready low for 10 cycles -> valid stays high and data is stable; o_rx_frame_ready=0 throughout.
- Truncation and zero length: len=0x2000 with SLOT=0x1000 -> BTT=0x1000 and STATUS bit1=1. len=0 -> no command, no irq, FRAME_CNT unchanged.
- Control edges:
  - Disable in WAIT_DONE -> frame completes, FSM reaches IDLE, o_rx_busy=0.
  - Clear written in the same cycle as done -> FRAME_CNT=0.
  - i_soft_rst in CMD -> all outputs 0 the next cycle.
- Register reads: read 0x0C and unmapped 0x1FC -> o_reg_valid pulses 1 cycle after i_reg_ren; unmapped read returns 0.
